// File: rtl/pu_pkg.sv
// Shared widths, word type and controller state encoding for the maxnet PU bank.
package pu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_PE   = 4;
  localparam int unsigned IDX_W  = $clog2(N_PE);
  localparam int unsigned CNT_W  = IDX_W + 1;

  typedef logic [DATA_W-1:0] fp_word_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    SUM  = 3'd2,
    EVAL = 3'd3,
    DONE = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CNT_ZERO = 2'd0,
    CNT_ONE  = 2'd1,
    CNT_MANY = 2'd2
  } sole_cnt_t;

  // Result payload presented to the host after termination.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    fp_word_t         val;
    logic             no_winner;
    logic             timeout;
  } result_t;

endpackage

// File: rtl/maxnet_controller_sole_one_detect.sv
// Classifies the PU nonzero flags as none / exactly one / several and encodes the set index.
module sole_one_detect
  import pu_pkg::*;
(
  input  logic [N_PE-1:0]  flags,
  output sole_cnt_t        count_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [CNT_W-1:0] ones;

  always_comb begin
    ones  = '0;
    idx_c = '0;
    for (int i = 0; i < int'(N_PE); i++) begin
      ones = ones + CNT_W'(flags[i]);
      if (flags[i]) idx_c = IDX_W'(i);
    end
  end

  always_comb begin
    count_c = CNT_MANY;
    if (ones == CNT_W'(0))      count_c = CNT_ZERO;
    else if (ones == CNT_W'(1)) count_c = CNT_ONE;
  end

endmodule

// File: rtl/maxnet_controller.sv
// Maxnet iteration controller: broadcasts x to the PU bank, strobes mult/sum, evaluates
// the returned flags and feeds outputs back until a sole winner, all-zero, or the iteration limit.
module maxnet_controller
  import pu_pkg::*;
#(
  parameter  int unsigned MAX_ITER = 16,
  localparam int unsigned ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [N_PE*DATA_W-1:0]   in_data,
  input  logic [N_PE*DATA_W-1:0]   pu_out,
  input  logic [N_PE-1:0]          pu_s,
  output logic [N_PE*DATA_W-1:0]   pu_x,
  output logic                     load_mult,
  output logic                     load_sum,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         winner_idx,
  output logic [DATA_W-1:0]        winner_val,
  output logic                     no_winner,
  output logic                     timeout,
  output logic [ITER_W-1:0]        iter_count
);

  ctrl_state_t               state_q, state_d;
  logic [N_PE*DATA_W-1:0]    pu_x_d;
  logic                      load_mult_d, load_sum_d, busy_d, done_d;
  logic [ITER_W-1:0]         iter_d, iter_inc_c, iter_sat_c;
  result_t                   res_q, res_d;
  sole_cnt_t                 cnt_c;
  logic [IDX_W-1:0]          idx_c;
  fp_word_t                  sel_val_c;

  sole_one_detect u_detect (
    .flags   (pu_s),
    .count_c (cnt_c),
    .idx_c   (idx_c)
  );

  // Lane value of the detected winner.
  always_comb begin
    sel_val_c = '0;
    for (int i = 0; i < int'(N_PE); i++) begin
      if (idx_c == IDX_W'(i)) sel_val_c = pu_out[i*DATA_W +: DATA_W];
    end
  end

  assign iter_inc_c = iter_count + ITER_W'(1);
  assign iter_sat_c = (iter_count == ITER_W'(MAX_ITER)) ? iter_count : iter_inc_c;

  // Next-state and next-output decode; strobes are decoded one cycle early so the
  // registered copies line up with the MULT and SUM states.
  always_comb begin
    state_d     = state_q;
    pu_x_d      = pu_x;
    load_mult_d = 1'b0;
    load_sum_d  = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    iter_d      = iter_count;
    res_d       = res_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pu_x_d      = in_data;
          iter_d      = '0;
          res_d       = '0;
          busy_d      = 1'b1;
          load_mult_d = 1'b1;
          state_d     = MULT;
        end
      end
      MULT: begin
        load_sum_d = 1'b1;
        state_d    = SUM;
      end
      SUM: begin
        state_d = EVAL;
      end
      EVAL: begin
        iter_d = iter_sat_c;
        case (cnt_c)
          CNT_ONE: begin
            res_d.idx = idx_c;
            res_d.val = sel_val_c;
            state_d   = DONE;
          end
          CNT_ZERO: begin
            res_d.no_winner = 1'b1;
            res_d.idx       = '0;
            res_d.val       = '0;
            state_d         = DONE;
          end
          default: begin
            if (iter_inc_c == ITER_W'(MAX_ITER)) begin
              res_d.timeout = 1'b1;
              state_d       = DONE;
            end else begin
              pu_x_d      = pu_out;
              load_mult_d = 1'b1;
              state_d     = MULT;
            end
          end
        endcase
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pu_x       <= '0;
      load_mult  <= 1'b0;
      load_sum   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iter_count <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      pu_x       <= pu_x_d;
      load_mult  <= load_mult_d;
      load_sum   <= load_sum_d;
      busy       <= busy_d;
      done       <= done_d;
      iter_count <= iter_d;
      res_q      <= res_d;
    end
  end

  assign winner_idx = res_q.idx;
  assign winner_val = res_q.val;
  assign no_winner  = res_q.no_winner;
  assign timeout    = res_q.timeout;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller with a scripted PU stub answering each EVAL.
module tb_maxnet_controller;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [127:0] in_data;
  logic [127:0] pu_out;
  logic [3:0]   pu_s;
  logic [127:0] pu_x;
  logic         load_mult, load_sum, busy, done;
  logic [1:0]   winner_idx;
  logic [31:0]  winner_val;
  logic         no_winner, timeout;
  logic [4:0]   iter_count;

  int total = 0;
  int bad   = 0;

  maxnet_controller #(.MAX_ITER(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .in_data    (in_data),
    .pu_out     (pu_out),
    .pu_s       (pu_s),
    .pu_x       (pu_x),
    .load_mult  (load_mult),
    .load_sum   (load_sum),
    .busy       (busy),
    .done       (done),
    .winner_idx (winner_idx),
    .winner_val (winner_val),
    .no_winner  (no_winner),
    .timeout    (timeout),
    .iter_count (iter_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [127:0]       in_data;
    int                 n_seq;
    logic [3:0][3:0]    s_seq;
    logic [3:0][127:0]  out_seq;
    bit                 hold_start;
    int                 lat;
    logic [1:0]         idx;
    logic [31:0]        val;
    logic               no_win;
    logic               tout;
    logic [4:0]         iter;
  } vec_t;

  vec_t         vecs[6];
  vec_t         cur;
  int           stub_k;
  logic [127:0] mult_x[$];
  bit           both_seen = 0;
  int           done_cnt  = 0;

  // PU stub: presents the next scripted answer during SUM so it is stable through EVAL.
  always @(negedge clock) begin
    int j;
    if (load_sum) begin
      j      = (stub_k < cur.n_seq) ? stub_k : cur.n_seq - 1;
      pu_s   = cur.s_seq[j];
      pu_out = cur.out_seq[j];
      stub_k = stub_k + 1;
    end
    if (load_mult) mult_x.push_back(pu_x);
    if (load_mult && load_sum) both_seen = 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] din, input int n,
                              input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [127:0] o0, input logic [127:0] o1, input logic [127:0] o2,
                              input bit hold, input int lat, input logic [1:0] idx,
                              input logic [31:0] val, input logic nw, input logic to,
                              input logic [4:0] iter);
    vec_t v;
    v.in_data = din;  v.n_seq = n;
    v.s_seq[0] = s0;  v.s_seq[1] = s1;  v.s_seq[2] = s2;  v.s_seq[3] = 4'b0;
    v.out_seq[0] = o0; v.out_seq[1] = o1; v.out_seq[2] = o2; v.out_seq[3] = '0;
    v.hold_start = hold; v.lat = lat; v.idx = idx; v.val = val;
    v.no_win = nw; v.tout = to; v.iter = iter;
    return v;
  endfunction

  // Launch one operation and return the cycle count from the start edge to done.
  task automatic run_op(input vec_t v, input string tag);
    int  lat;
    bit  x_ok;
    int  k;
    logic [127:0] exp_x;
    cur    = v;
    stub_k = 0;
    mult_x.delete();
    @(negedge clock);
    in_data = v.in_data;
    start   = 1'b1;
    @(posedge clock);
    #1;
    if (!v.hold_start) start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock);
      #1;
      if (done) begin lat = c; break; end
    end
    start = 1'b0;
    check({tag, " latency"}, 128'(lat), 128'(v.lat));
    check({tag, " winner_idx"}, 128'(winner_idx), 128'(v.idx));
    check({tag, " winner_val"}, 128'(winner_val), 128'(v.val));
    check({tag, " no_winner"}, 128'(no_winner), 128'(v.no_win));
    check({tag, " timeout"}, 128'(timeout), 128'(v.tout));
    check({tag, " iter_count"}, 128'(iter_count), 128'(v.iter));
    check({tag, " busy at done"}, 128'(busy), 128'(0));
    check({tag, " mult count"}, 128'(mult_x.size()), 128'(v.iter));
    x_ok = (mult_x.size() == int'(v.iter));
    for (int m = 0; m < mult_x.size(); m++) begin
      k     = (m - 1 < v.n_seq - 1) ? m - 1 : v.n_seq - 1;
      exp_x = (m == 0) ? v.in_data : v.out_seq[k];
      if (mult_x[m] !== exp_x) x_ok = 0;
    end
    check({tag, " pu_x per MULT"}, 128'(x_ok), 128'(1));
    @(posedge clock);
    #1;
    check({tag, " done one cycle"}, 128'(done), 128'(0));
    repeat (3) @(posedge clock);
    #1;
    check({tag, " idle after done"}, 128'({busy, load_mult, load_sum}), 128'(0));
    check({tag, " result held"}, 128'({winner_idx, winner_val, no_winner, timeout}),
          128'({v.idx, v.val, v.no_win, v.tout}));
  endtask

  initial begin
    int  snap;
    bit  seen;
    reset_n = 1'b0;
    start   = 1'b0;
    in_data = '0;
    pu_out  = '0;
    pu_s    = '0;

    vecs[0] = mk({32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000}, 1,
                 4'b0100, 4'b0, 4'b0,
                 {32'h0, 32'h3E800000, 32'h0, 32'h0}, '0, '0,
                 0, 4, 2'd2, 32'h3E800000, 0, 0, 5'd1);
    vecs[1] = mk({32'h40000000, 32'h3F800000, 32'h3F400000, 32'h3F000000}, 3,
                 4'b1111, 4'b0110, 4'b0010,
                 {32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000},
                 {32'h0, 32'h3F400000, 32'h3E000000, 32'h0},
                 {32'h0, 32'h0, 32'h3D800000, 32'h0},
                 1, 10, 2'd1, 32'h3D800000, 0, 0, 5'd3);
    vecs[2] = mk({32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 1,
                 4'b0000, 4'b0, 4'b0, '0, '0, '0,
                 0, 4, 2'd0, 32'h0, 1, 0, 5'd1);
    vecs[3] = mk({32'h0, 32'h0, 32'h3F800000, 32'h3F800000}, 1,
                 4'b0011, 4'b0, 4'b0,
                 {32'h0, 32'h0, 32'h3F800000, 32'h3F800000}, '0, '0,
                 0, 49, 2'd0, 32'h0, 0, 1, 5'd16);
    vecs[4] = mk({32'h41200000, 32'h0, 32'h0, 32'h3F800000}, 2,
                 4'b1001, 4'b1000, 4'b0,
                 {32'h41000000, 32'h0, 32'h0, 32'h3E000000},
                 {32'h40C00000, 32'h0, 32'h0, 32'h0}, '0,
                 0, 7, 2'd3, 32'h40C00000, 0, 0, 5'd2);
    vecs[5] = mk({32'h0, 32'h0, 32'h0, 32'h40400000}, 1,
                 4'b0001, 4'b0, 4'b0,
                 {32'h0, 32'h0, 32'h0, 32'h40000000}, '0, '0,
                 0, 4, 2'd0, 32'h40000000, 0, 0, 5'd1);

    // Reset values.
    repeat (2) @(posedge clock);
    #1;
    check("reset pu_x", pu_x, 128'(0));
    check("reset ctrl", 128'({load_mult, load_sum, busy, done}), 128'(0));
    check("reset result", 128'({winner_idx, winner_val, no_winner, timeout, iter_count}), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Abort in SUM: strobe and state return to reset values, no done pulse.
    cur    = vecs[3];
    stub_k = 0;
    @(negedge clock);
    in_data = vecs[0].in_data;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen  = 0;
    for (int c = 0; c < 10; c++) begin
      if (load_sum) begin seen = 1; break; end
      @(negedge clock);
    end
    check("abort reached SUM", 128'(seen), 128'(1));
    snap    = done_cnt;
    reset_n = 1'b0;
    #1;
    check("abort load_sum", 128'(load_sum), 128'(0));
    check("abort busy", 128'(busy), 128'(0));
    check("abort pu_x", pu_x, 128'(0));
    check("abort iter_count", 128'(iter_count), 128'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("abort no done", 128'(done_cnt - snap), 128'(0));
    check("abort idle", 128'({busy, load_mult, load_sum}), 128'(0));
    run_op(vecs[0], "after abort");

    check("strobes never overlap", 128'(both_seen), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
